// File: rtl/exe_lsu.sv
// EXE-stage load/store front end: one ID->EXE slot, effective address and alignment check, SRAM-like request issue.
// Result reaches MEM in the addr_ok cycle (memory op) or one cycle after the slot is loaded; it stalls on !ms_allowin or a missing addr_ok.
module exe_lsu #(
   parameter int         SB_WD   = 80,
   parameter logic [4:0] NO_EX   = 5'h1f,
   parameter logic [4:0] EX_ADEL = 5'h04,
   parameter logic [4:0] EX_ADES = 5'h05
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             ms_allowin,
   output logic             es_allowin,
   input  logic             ds_to_es_valid,
   input  logic [3:0]       ds_mem_op,
   input  logic [31:0]      ds_base,
   input  logic [15:0]      ds_offset,
   input  logic [31:0]      ds_rt_value,
   input  logic [4:0]       ds_ex_code,
   input  logic [SB_WD-1:0] ds_sideband,
   input  logic             flush,
   input  logic             ms_ex,
   output logic             es_to_ms_valid,
   output logic [31:0]      es_mem_addr,
   output logic [1:0]       es_ldb,
   output logic [3:0]       es_mem_op,
   output logic [31:0]      es_rt_value,
   output logic [4:0]       es_ex_code,
   output logic [31:0]      es_badvaddr,
   output logic [SB_WD-1:0] es_sideband,
   output logic             cancel_resp,
   output logic             data_sram_req,
   output logic             data_sram_wr,
   output logic [1:0]       data_sram_size,
   output logic [31:0]      data_sram_addr,
   output logic [3:0]       data_sram_wstrb,
   output logic [31:0]      data_sram_wdata,
   input  logic             data_sram_addr_ok
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REQ    = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;
   localparam logic [1:0] S_CANCEL = 2'd3;

   localparam logic [3:0] OP_LB  = 4'd1,  OP_LBU = 4'd2,  OP_LH  = 4'd3,  OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5,  OP_LWL = 4'd6,  OP_LWR = 4'd7,  OP_SB  = 4'd8;
   localparam logic [3:0] OP_SH  = 4'd9,  OP_SW  = 4'd10, OP_SWL = 4'd11, OP_SWR = 4'd12;

   logic [1:0]       state;
   logic             valid;
   logic             issued;
   logic [31:0]      addr_q;
   logic [31:0]      rt_q;
   logic [31:0]      bad_q;
   logic [3:0]       op_q;
   logic [4:0]       ex_q;
   logic [SB_WD-1:0] sb_q;

   logic [31:0] ds_addr;
   logic        ds_load;
   logic        ds_store;
   logic        ds_misalign;
   logic [4:0]  ds_ex;
   logic [31:0] ds_bad;
   logic        ds_go_req;

   always_comb begin
      ds_addr     = ds_base + {{16{ds_offset[15]}}, ds_offset};
      ds_load     = (ds_mem_op >= OP_LB) && (ds_mem_op <= OP_LWR);
      ds_store    = (ds_mem_op >= OP_SB) && (ds_mem_op <= OP_SWR);
      ds_misalign = 1'b0;
      case (ds_mem_op)
         OP_LH, OP_LHU, OP_SH: ds_misalign = ds_addr[0];
         OP_LW, OP_SW:         ds_misalign = |ds_addr[1:0];
         default:              ds_misalign = 1'b0;
      endcase
      ds_ex  = NO_EX;
      ds_bad = 32'd0;
      if (ds_ex_code != NO_EX) begin
         ds_ex = ds_ex_code;
      end else if (ds_misalign) begin
         ds_ex  = ds_store ? EX_ADES : EX_ADEL;
         ds_bad = ds_addr;
      end
      ds_go_req = (ds_load || ds_store) && (ds_ex == NO_EX);
   end

   logic is_load_q;
   logic is_store_q;
   logic req;
   logic handshake;
   logic ready_go;
   logic load_en;

   // Once on the bus a request is held through flush and ms_ex; only the first issue is gated.
   assign is_load_q  = (op_q >= OP_LB) && (op_q <= OP_LWR);
   assign is_store_q = (op_q >= OP_SB) && (op_q <= OP_SWR);
   assign req        = ((state == S_REQ) && valid && (issued || (!flush && !ms_ex)))
                       || (state == S_CANCEL);
   assign handshake  = req && data_sram_addr_ok;
   assign ready_go   = (state == S_DONE) || ((state == S_REQ) && handshake && !flush);
   assign es_to_ms_valid = valid && ready_go;
   assign es_allowin = (!valid || (ready_go && ms_allowin)) && (state != S_CANCEL);
   assign load_en    = ds_to_es_valid && es_allowin && !flush;
   assign cancel_resp = is_load_q && handshake
                        && ((state == S_CANCEL) || ((state == S_REQ) && flush));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= S_IDLE;
         valid  <= 1'b0;
         issued <= 1'b0;
         addr_q <= 32'd0;
         rt_q   <= 32'd0;
         bad_q  <= 32'd0;
         op_q   <= 4'd0;
         ex_q   <= NO_EX;
         sb_q   <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         if ((((state == S_REQ) && issued) || (state == S_CANCEL)) && !handshake) begin
            state  <= S_CANCEL;
            issued <= 1'b1;
         end else begin
            state  <= S_IDLE;
            issued <= 1'b0;
         end
      end else if (load_en) begin
         valid  <= 1'b1;
         state  <= ds_go_req ? S_REQ : S_DONE;
         issued <= 1'b0;
         addr_q <= ds_addr;
         rt_q   <= ds_rt_value;
         bad_q  <= ds_bad;
         op_q   <= ds_mem_op;
         ex_q   <= ds_ex;
         sb_q   <= ds_sideband;
      end else if (es_to_ms_valid && ms_allowin) begin
         valid  <= 1'b0;
         state  <= S_IDLE;
         issued <= 1'b0;
      end else if (state == S_REQ) begin
         if (handshake) begin
            state  <= S_DONE;
            issued <= 1'b0;
         end else begin
            issued <= issued | req;
         end
      end else if ((state == S_CANCEL) && handshake) begin
         state  <= S_IDLE;
         issued <= 1'b0;
      end
   end

   logic [1:0] a;
   assign a = addr_q[1:0];

   always_comb begin
      data_sram_size  = 2'd0;
      data_sram_addr  = addr_q;
      data_sram_wstrb = 4'b0000;
      data_sram_wdata = 32'd0;
      case (op_q)
         OP_LB, OP_LBU: data_sram_size = 2'd0;
         OP_LH, OP_LHU: data_sram_size = 2'd1;
         OP_LW:         data_sram_size = 2'd2;
         OP_LWL, OP_LWR: begin
            data_sram_size = 2'd2;
            data_sram_addr = {addr_q[31:2], 2'b00};
         end
         OP_SB: begin
            data_sram_size  = 2'd0;
            data_sram_wstrb = 4'b0001 << a;
            data_sram_wdata = {4{rt_q[7:0]}};
         end
         OP_SH: begin
            data_sram_size  = 2'd1;
            data_sram_wstrb = a[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{rt_q[15:0]}};
         end
         OP_SW: begin
            data_sram_size  = 2'd2;
            data_sram_wstrb = 4'b1111;
            data_sram_wdata = rt_q;
         end
         OP_SWL: begin
            data_sram_size = 2'd2;
            data_sram_addr = {addr_q[31:2], 2'b00};
            case (a)
               2'd0:    begin data_sram_wstrb = 4'b0001; data_sram_wdata = {24'd0, rt_q[31:24]}; end
               2'd1:    begin data_sram_wstrb = 4'b0011; data_sram_wdata = {16'd0, rt_q[31:16]}; end
               2'd2:    begin data_sram_wstrb = 4'b0111; data_sram_wdata = {8'd0, rt_q[31:8]};   end
               default: begin data_sram_wstrb = 4'b1111; data_sram_wdata = rt_q;                 end
            endcase
         end
         OP_SWR: begin
            data_sram_size = 2'd2;
            data_sram_addr = {addr_q[31:2], 2'b00};
            case (a)
               2'd0:    begin data_sram_wstrb = 4'b1111; data_sram_wdata = rt_q;                 end
               2'd1:    begin data_sram_wstrb = 4'b1110; data_sram_wdata = {rt_q[23:0], 8'd0};  end
               2'd2:    begin data_sram_wstrb = 4'b1100; data_sram_wdata = {rt_q[15:0], 16'd0}; end
               default: begin data_sram_wstrb = 4'b1000; data_sram_wdata = {rt_q[7:0], 24'd0};  end
            endcase
         end
         default: begin
            data_sram_size = 2'd0;
            data_sram_addr = addr_q;
         end
      endcase
   end

   assign data_sram_req = req;
   assign data_sram_wr  = is_store_q;
   assign es_mem_addr   = addr_q;
   assign es_ldb        = addr_q[1:0];
   assign es_mem_op     = op_q;
   assign es_rt_value   = rt_q;
   assign es_ex_code    = ex_q;
   assign es_badvaddr   = bad_q;
   assign es_sideband   = sb_q;

endmodule

// File: tb/tb_exe_lsu.sv
// Bench for exe_lsu: vector table with a scoreboard queue, plus hand sequences for stalls, flush/cancel, ms_ex and reset.
module tb_exe_lsu;

   localparam logic [4:0] NO = 5'h1f;

   logic        clk;
   logic        resetn;
   logic        ms_allowin;
   logic        es_allowin;
   logic        ds_to_es_valid;
   logic [3:0]  ds_mem_op;
   logic [31:0] ds_base;
   logic [15:0] ds_offset;
   logic [31:0] ds_rt_value;
   logic [4:0]  ds_ex_code;
   logic [79:0] ds_sideband;
   logic        flush;
   logic        ms_ex;
   logic        es_to_ms_valid;
   logic [31:0] es_mem_addr;
   logic [1:0]  es_ldb;
   logic [3:0]  es_mem_op;
   logic [31:0] es_rt_value;
   logic [4:0]  es_ex_code;
   logic [31:0] es_badvaddr;
   logic [79:0] es_sideband;
   logic        cancel_resp;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;

   exe_lsu dut (
      .clk(clk), .resetn(resetn), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
      .ds_to_es_valid(ds_to_es_valid), .ds_mem_op(ds_mem_op), .ds_base(ds_base),
      .ds_offset(ds_offset), .ds_rt_value(ds_rt_value), .ds_ex_code(ds_ex_code),
      .ds_sideband(ds_sideband), .flush(flush), .ms_ex(ms_ex),
      .es_to_ms_valid(es_to_ms_valid), .es_mem_addr(es_mem_addr), .es_ldb(es_ldb),
      .es_mem_op(es_mem_op), .es_rt_value(es_rt_value), .es_ex_code(es_ex_code),
      .es_badvaddr(es_badvaddr), .es_sideband(es_sideband), .cancel_resp(cancel_resp),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
      .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] base;
      logic [15:0] off;
      logic [31:0] rt;
      logic [4:0]  exin;
      logic [31:0] addr;
      logic [4:0]  ex;
      logic [31:0] bad;
      logic        req;
      logic [1:0]  size;
      logic [31:0] saddr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [79:0] sb;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   vec_t vt[19];
   vec_t exp_q[$];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req_v);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off,
                               input logic [31:0] rt, input logic [4:0] exin, input logic [31:0] addr,
                               input logic [4:0] ex, input logic [31:0] bad, input logic req,
                               input logic [1:0] size, input logic [31:0] saddr,
                               input logic [3:0] wstrb, input logic [31:0] wdata);
      vec_t v;
      v.op = op; v.base = base; v.off = off; v.rt = rt; v.exin = exin;
      v.addr = addr; v.ex = ex; v.bad = bad; v.req = req; v.size = size;
      v.saddr = saddr; v.wstrb = wstrb; v.wdata = wdata;
      v.sb = {16'hA5C3, base ^ 32'h5a5a0000, rt};
      return v;
   endfunction

   task automatic drive_ds(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off,
                           input logic [31:0] rt, input logic [4:0] exin, input logic [79:0] sb);
      ds_mem_op = op; ds_base = base; ds_offset = off; ds_rt_value = rt;
      ds_ex_code = exin; ds_sideband = sb;
   endtask

   task automatic load_slot(input logic [3:0] op, input logic [31:0] base, input logic [15:0] off,
                            input logic [31:0] rt);
      @(negedge clk);
      drive_ds(op, base, off, rt, NO, 80'h0);
      ds_to_es_valid = 1'b1;
      @(negedge clk);
      ds_to_es_valid = 1'b0;
   endtask

   task automatic cmp_out(input string tag);
      vec_t e;
      if (exp_q.size() == 0) begin
         chk({tag, " scoreboard_empty"}, 1, 0);
         return;
      end
      e = exp_q.pop_front();
      chk({tag, " es_mem_addr"}, es_mem_addr, e.addr);
      chk({tag, " es_ldb"}, es_ldb, e.addr[1:0]);
      chk({tag, " es_ex_code"}, es_ex_code, e.ex);
      chk({tag, " es_badvaddr"}, es_badvaddr, e.bad);
      chk({tag, " es_mem_op"}, es_mem_op, e.op);
      chk({tag, " es_rt_value"}, es_rt_value, e.rt);
      chk({tag, " es_sideband"}, es_sideband, e.sb);
   endtask

   task automatic run_vec(input int i);
      vec_t  v;
      bit    done;
      string tag;
      v    = vt[i];
      tag  = $sformatf("vec%0d", i);
      done = 0;
      @(negedge clk);
      drive_ds(v.op, v.base, v.off, v.rt, v.exin, v.sb);
      ds_to_es_valid = 1'b1;
      #1 chk({tag, " es_allowin"}, es_allowin, 1);
      @(negedge clk);
      ds_to_es_valid = 1'b0;
      exp_q.push_back(v);
      for (int c = 0; c < 20 && !done; c++) begin
         if (data_sram_req) begin
            chk({tag, " req_expected"}, 1, v.req);
            chk({tag, " size"}, data_sram_size, v.size);
            chk({tag, " saddr"}, data_sram_addr, v.saddr);
            chk({tag, " wstrb"}, data_sram_wstrb, v.wstrb);
            chk({tag, " wdata"}, data_sram_wdata, v.wdata);
            chk({tag, " wr"}, data_sram_wr, (v.op >= 4'd8 && v.op <= 4'd12));
            data_sram_addr_ok = 1'b1;
            #1 chk({tag, " es_to_ms_valid"}, es_to_ms_valid, 1);
            cmp_out(tag);
            done = 1;
            @(posedge clk);
            #1 data_sram_addr_ok = 1'b0;
         end else if (es_to_ms_valid) begin
            chk({tag, " req_expected"}, 0, v.req);
            cmp_out(tag);
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         chk({tag, " timeout"}, 0, 1);
         void'(exp_q.pop_front());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      clk = 0; resetn = 0; ms_allowin = 1; ds_to_es_valid = 0; flush = 0; ms_ex = 0;
      data_sram_addr_ok = 0;
      drive_ds(4'd0, 32'd0, 16'd0, 32'd0, NO, 80'd0);

      //        op     base          off       rt            exin   addr          ex     bad           req size saddr        wstrb    wdata
      vt[0]  = mk(4'd10, 32'h00001000, 16'hfffc, 32'hdeadbeef, NO,    32'h00000ffc, NO,    32'h0,        1, 2, 32'h00000ffc, 4'b1111, 32'hdeadbeef);
      vt[1]  = mk(4'd3,  32'h00002001, 16'h0000, 32'h00000000, NO,    32'h00002001, 5'h04, 32'h00002001, 0, 0, 32'h0,        4'b0000, 32'h0);
      vt[2]  = mk(4'd11, 32'h00003000, 16'h0002, 32'h11223344, NO,    32'h00003002, NO,    32'h0,        1, 2, 32'h00003000, 4'b0111, 32'h00112233);
      vt[3]  = mk(4'd12, 32'h00003000, 16'h0001, 32'h11223344, NO,    32'h00003001, NO,    32'h0,        1, 2, 32'h00003000, 4'b1110, 32'h22334400);
      vt[4]  = mk(4'd8,  32'h00004000, 16'h0003, 32'h11223344, NO,    32'h00004003, NO,    32'h0,        1, 0, 32'h00004003, 4'b1000, 32'h44444444);
      vt[5]  = mk(4'd9,  32'h00004000, 16'h0002, 32'haabbccdd, NO,    32'h00004002, NO,    32'h0,        1, 1, 32'h00004002, 4'b1100, 32'hccddccdd);
      vt[6]  = mk(4'd9,  32'h00004000, 16'h0001, 32'haabbccdd, NO,    32'h00004001, 5'h05, 32'h00004001, 0, 0, 32'h0,        4'b0000, 32'h0);
      vt[7]  = mk(4'd10, 32'h00005002, 16'h0000, 32'h12345678, NO,    32'h00005002, 5'h05, 32'h00005002, 0, 0, 32'h0,        4'b0000, 32'h0);
      vt[8]  = mk(4'd5,  32'h00006000, 16'h0008, 32'h0badf00d, NO,    32'h00006008, NO,    32'h0,        1, 2, 32'h00006008, 4'b0000, 32'h0);
      vt[9]  = mk(4'd6,  32'h00006000, 16'h0007, 32'h0badf00d, NO,    32'h00006007, NO,    32'h0,        1, 2, 32'h00006004, 4'b0000, 32'h0);
      vt[10] = mk(4'd2,  32'hffffffff, 16'h0001, 32'h00000000, NO,    32'h00000000, NO,    32'h0,        1, 0, 32'h00000000, 4'b0000, 32'h0);
      vt[11] = mk(4'd4,  32'h00000010, 16'h8000, 32'h00000000, NO,    32'hffff8010, NO,    32'h0,        1, 1, 32'hffff8010, 4'b0000, 32'h0);
      vt[12] = mk(4'd5,  32'h00007000, 16'h0001, 32'h00000000, 5'h0a, 32'h00007001, 5'h0a, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0);
      vt[13] = mk(4'd0,  32'h00000100, 16'h0004, 32'h00000000, NO,    32'h00000104, NO,    32'h0,        0, 0, 32'h0,        4'b0000, 32'h0);
      vt[14] = mk(4'd11, 32'h00008000, 16'h0000, 32'h11223344, NO,    32'h00008000, NO,    32'h0,        1, 2, 32'h00008000, 4'b0001, 32'h00000011);
      vt[15] = mk(4'd12, 32'h00008003, 16'h0000, 32'h11223344, NO,    32'h00008003, NO,    32'h0,        1, 2, 32'h00008000, 4'b1000, 32'h44000000);
      vt[16] = mk(4'd13, 32'h00000200, 16'h0000, 32'h00000000, NO,    32'h00000200, NO,    32'h0,        0, 0, 32'h0,        4'b0000, 32'h0);
      vt[17] = mk(4'd7,  32'h00009000, 16'hfffe, 32'h00000000, NO,    32'h00008ffe, NO,    32'h0,        1, 2, 32'h00008ffc, 4'b0000, 32'h0);
      vt[18] = mk(4'd10, 32'h00009000, 16'hfffe, 32'h00000000, NO,    32'h00008ffe, 5'h05, 32'h00008ffe, 0, 0, 32'h0,        4'b0000, 32'h0);

      #12;
      chk("rst es_allowin", es_allowin, 1);
      chk("rst es_ex_code", es_ex_code, NO);
      chk("rst es_to_ms_valid", es_to_ms_valid, 0);
      chk("rst req", data_sram_req, 0);
      chk("rst es_mem_addr", es_mem_addr, 0);
      chk("rst es_badvaddr", es_badvaddr, 0);
      chk("rst wstrb", data_sram_wstrb, 0);
      chk("rst cancel_resp", cancel_resp, 0);
      @(negedge clk);
      resetn = 1;

      for (int i = 0; i < 19; i++) run_vec(i);

      // SW held three cycles until addr_ok
      load_slot(4'd10, 32'h00001000, 16'hfffc, 32'hdeadbeef);
      #1 chk("sw c1 req", data_sram_req, 1);
      chk("sw c1 to_ms", es_to_ms_valid, 0);
      @(negedge clk);
      #1 chk("sw c2 req", data_sram_req, 1);
      chk("sw c2 saddr", data_sram_addr, 32'h00000ffc);
      @(negedge clk);
      chk("sw c3 req", data_sram_req, 1);
      chk("sw c3 wdata", data_sram_wdata, 32'hdeadbeef);
      chk("sw c3 wstrb", data_sram_wstrb, 4'b1111);
      data_sram_addr_ok = 1;
      #1 chk("sw c3 to_ms", es_to_ms_valid, 1);
      @(posedge clk);
      #1 data_sram_addr_ok = 0;
      @(negedge clk);
      chk("sw after req", data_sram_req, 0);
      chk("sw after to_ms", es_to_ms_valid, 0);

      // LB flushed after issue -> CANCEL, one cancel_resp
      load_slot(4'd1, 32'h00009000, 16'h0001, 32'h0);
      #1 chk("cxl issue req", data_sram_req, 1);
      chk("cxl size", data_sram_size, 0);
      @(negedge clk);
      flush = 1;
      #1 chk("cxl flush allowin", es_allowin, 0);
      chk("cxl flush to_ms", es_to_ms_valid, 0);
      @(negedge clk);
      flush = 0;
      #1 chk("cxl hold req", data_sram_req, 1);
      chk("cxl hold saddr", data_sram_addr, 32'h00009001);
      chk("cxl hold allowin", es_allowin, 0);
      chk("cxl hold cancel_resp", cancel_resp, 0);
      @(negedge clk);
      data_sram_addr_ok = 1;
      #1 chk("cxl ack cancel_resp", cancel_resp, 1);
      chk("cxl ack to_ms", es_to_ms_valid, 0);
      @(posedge clk);
      #1 data_sram_addr_ok = 0;
      @(negedge clk);
      chk("cxl done cancel_resp", cancel_resp, 0);
      chk("cxl done req", data_sram_req, 0);
      chk("cxl done allowin", es_allowin, 1);

      // ms_ex holds back first issue of an SB
      ms_ex = 1;
      load_slot(4'd8, 32'h0000a000, 16'h0001, 32'h000000a5);
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("msex c%0d req", k), data_sram_req, 0);
         @(negedge clk);
      end
      ms_ex = 0;
      #1 chk("msex rise req", data_sram_req, 1);
      chk("msex wstrb", data_sram_wstrb, 4'b0010);
      chk("msex wdata", data_sram_wdata, 32'ha5a5a5a5);
      chk("msex size", data_sram_size, 0);
      data_sram_addr_ok = 1;
      #1 chk("msex to_ms", es_to_ms_valid, 1);
      @(posedge clk);
      #1 data_sram_addr_ok = 0;

      // MEM stalls after addr_ok: slot parks in DONE
      ms_allowin = 0;
      load_slot(4'd5, 32'h0000b000, 16'h0004, 32'h0);
      data_sram_addr_ok = 1;
      #1 chk("stall ack to_ms", es_to_ms_valid, 1);
      @(posedge clk);
      #1 data_sram_addr_ok = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("stall c%0d req", k), data_sram_req, 0);
         chk($sformatf("stall c%0d to_ms", k), es_to_ms_valid, 1);
         chk($sformatf("stall c%0d addr", k), es_mem_addr, 32'h0000b004);
         chk($sformatf("stall c%0d allowin", k), es_allowin, 0);
      end
      ms_allowin = 1;
      #1 chk("stall release allowin", es_allowin, 1);

      // back-to-back LW with addr_ok tied high
      @(negedge clk);
      data_sram_addr_ok = 1;
      drive_ds(4'd5, 32'h0000c000, 16'h0000, 32'h0, NO, 80'h0);
      ds_to_es_valid = 1;
      @(negedge clk);
      drive_ds(4'd5, 32'h0000c000, 16'h0004, 32'h0, NO, 80'h0);
      #1 chk("b2b first req", data_sram_req, 1);
      chk("b2b first saddr", data_sram_addr, 32'h0000c000);
      chk("b2b first allowin", es_allowin, 1);
      @(negedge clk);
      ds_to_es_valid = 0;
      #1 chk("b2b second req", data_sram_req, 1);
      chk("b2b second saddr", data_sram_addr, 32'h0000c004);
      chk("b2b second to_ms", es_to_ms_valid, 1);
      @(negedge clk);
      #1 chk("b2b idle req", data_sram_req, 0);
      chk("b2b idle to_ms", es_to_ms_valid, 0);
      data_sram_addr_ok = 0;

      // flush in the first REQ cycle issues nothing
      load_slot(4'd10, 32'h0000d000, 16'h0000, 32'h0);
      flush = 1;
      #1 chk("flush1 req", data_sram_req, 0);
      @(negedge clk);
      flush = 0;
      #1 chk("flush1 after req", data_sram_req, 0);
      chk("flush1 after to_ms", es_to_ms_valid, 0);
      chk("flush1 after allowin", es_allowin, 1);

      // async reset mid-handshake
      load_slot(4'd10, 32'h0000e000, 16'h0000, 32'h0);
      #1 chk("arst pre req", data_sram_req, 1);
      resetn = 0;
      #1 chk("arst req", data_sram_req, 0);
      chk("arst allowin", es_allowin, 1);
      chk("arst ex_code", es_ex_code, NO);
      chk("arst addr", es_mem_addr, 0);
      @(negedge clk);
      resetn = 1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
